// File: rtl/fetch_responder.sv
// fetch_responder: instruction-side responder between fetch PC generation and
// the memory bus. It fetches 64-bit aligned words and keeps the most recent
// word in a one-entry line buffer, so the sibling instruction in the same word
// is returned without a bus transaction.
module fetch_responder #(
  parameter int ADDR_W = 64,
  parameter int BUS_W  = 64,
  parameter bit BUF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_flush,
  input  logic              buf_inval,
  output logic              sig_recvd,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic              bus_respcyc,
  input  logic [BUS_W-1:0]  bus_resp,
  output logic              bus_respack
);

  localparam int TAG_W  = ADDR_W - 3;
  localparam int HALF_W = BUS_W / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic                r_bus_req;
  logic                r_drop;
  logic                r_resp_valid;
  logic [31:0]         r_instr;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic                r_buf_valid;
  logic [TAG_W-1:0]    r_buf_tag;
  logic [BUS_W-1:0]    r_buf_data;

  logic [TAG_W-1:0]    w_req_tag;
  logic                w_hit;
  logic                w_accept;
  logic                w_fill;
  logic                w_drop_now;

  // Pick one 32-bit instruction out of a bus word; sel=0 is the low half.
  function automatic logic [31:0] select_half(input logic [BUS_W-1:0] word,
                                              input logic             sel);
    logic [HALF_W-1:0] half;
    half = sel ? word[BUS_W-1:HALF_W] : word[HALF_W-1:0];
    return half[31:0];
  endfunction

  assign w_req_tag  = fetch_pc[ADDR_W-1:3];
  // A store seen this very cycle already disqualifies the buffered word.
  assign w_hit      = BUF_EN && r_buf_valid && (w_req_tag == r_buf_tag) && !buf_inval;
  assign w_accept   = (r_state == S_IDLE) && fetch_req && !fetch_flush;
  assign w_fill     = (r_state == S_WAIT) && bus_respcyc;
  // A flush arriving together with the response still cancels delivery.
  assign w_drop_now = r_drop || fetch_flush;

  assign sig_recvd   = r_resp_valid && !fetch_flush;
  assign instr_out   = r_instr;
  assign instr_pc    = r_instr_pc;
  assign bus_req     = r_bus_req;
  assign bus_addr    = r_bus_addr;
  assign bus_respack = w_fill;

  // Request/response sequencing with registered bus and instruction outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_bus_addr   <= '0;
      r_bus_req    <= 1'b0;
      r_drop       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_instr      <= '0;
      r_instr_pc   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (w_accept) begin
            if (w_hit) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_instr      <= select_half(r_buf_data, fetch_pc[2]);
              r_instr_pc   <= fetch_pc;
            end else begin
              r_state    <= S_REQ;
              r_pc       <= fetch_pc;
              r_bus_addr <= {fetch_pc[ADDR_W-1:3], 3'b000};
              r_bus_req  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (fetch_flush) begin
            r_drop <= 1'b1;
          end
          // bus_req and bus_addr stay put until the bus takes the request.
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_respcyc) begin
            if (w_drop_now) begin
              r_state <= S_IDLE;
              r_drop  <= 1'b0;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_instr      <= select_half(bus_resp, r_pc[2]);
              r_instr_pc   <= r_pc;
            end
          end else if (fetch_flush) begin
            r_drop <= 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_drop  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
          r_drop    <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer validity; an invalidate beats a fill in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_valid <= 1'b0;
    end else if (buf_inval) begin
      r_buf_valid <= 1'b0;
    end else if (w_fill) begin
      r_buf_valid <= 1'b1;
    end
  end

  // Line buffer contents; qualified by r_buf_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_buf_data <= bus_resp;
      r_buf_tag  <= r_pc[ADDR_W-1:3];
    end
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Directed testbench for fetch_responder: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_fetch_responder;

  logic        clk;
  logic        reset_n;
  logic        fetch_req;
  logic [63:0] fetch_pc;
  logic        fetch_flush;
  logic        buf_inval;
  logic        sig_recvd;
  logic [31:0] instr_out;
  logic [63:0] instr_pc;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic        bus_ack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic        bus_respack;

  int n_checks;
  int n_fail;

  fetch_responder #(.ADDR_W(64), .BUS_W(64), .BUF_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_flush(fetch_flush), .buf_inval(buf_inval), .sig_recvd(sig_recvd),
    .instr_out(instr_out), .instr_pc(instr_pc), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_respack(bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Complete a miss with immediate ack and response (stimulus only).
  task automatic fill(input logic [63:0] pc, input logic [63:0] data);
    fetch_req = 1'b1; fetch_pc = pc;
    cyc();
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0; bus_respcyc = 1'b1; bus_resp = data;
    cyc();
    bus_respcyc = 1'b0; fetch_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_init();
    #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL init_bus_req got=%0b want=0", bus_req); end
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL init_recvd got=%0b want=0", sig_recvd); end
    n_checks++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL init_instr got=%h want=0", instr_out); end
    n_checks++; if (bus_addr !== 64'h0) begin n_fail++; $display("FAIL init_bus_addr got=%h want=0", bus_addr); end
  endtask

  task automatic test_miss();
    fetch_req = 1'b1; fetch_pc = 64'h1000;
    cyc();
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL miss_bus_req got=%0b want=1", bus_req); end
    n_checks++; if (bus_addr !== 64'h1000) begin n_fail++; $display("FAIL miss_bus_addr got=%h want=1000", bus_addr); end
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL miss_early_recvd got=%0b want=0", sig_recvd); end
    cyc();
    cyc();
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL miss_req_held got=%0b want=1", bus_req); end
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL miss_req_drop got=%0b want=0", bus_req); end
    bus_respcyc = 1'b1; bus_resp = 64'hBBBBBBBB_AAAAAAAA;
    #1;
    n_checks++; if (bus_respack !== 1'b1) begin n_fail++; $display("FAIL miss_respack got=%0b want=1", bus_respack); end
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL miss_recvd_wait got=%0b want=0", sig_recvd); end
    cyc();
    bus_respcyc = 1'b0;
    n_checks++; if (sig_recvd !== 1'b1) begin n_fail++; $display("FAIL miss_recvd got=%0b want=1", sig_recvd); end
    n_checks++; if (instr_out !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL miss_instr got=%h want=aaaaaaaa", instr_out); end
    n_checks++; if (instr_pc !== 64'h1000) begin n_fail++; $display("FAIL miss_instr_pc got=%h want=1000", instr_pc); end
    fetch_req = 1'b0;
    cyc();
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_len got=%0b want=0", sig_recvd); end
  endtask

  task automatic test_hit();
    fetch_req = 1'b1; fetch_pc = 64'h1004;
    cyc();
    n_checks++; if (sig_recvd !== 1'b1) begin n_fail++; $display("FAIL hit_recvd got=%0b want=1", sig_recvd); end
    n_checks++; if (instr_out !== 32'hBBBBBBBB) begin n_fail++; $display("FAIL hit_instr got=%h want=bbbbbbbb", instr_out); end
    n_checks++; if (instr_pc !== 64'h1004) begin n_fail++; $display("FAIL hit_instr_pc got=%h want=1004", instr_pc); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL hit_bus_req got=%0b want=0", bus_req); end
    fetch_req = 1'b0;
    cyc();
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_len got=%0b want=0", sig_recvd); end
  endtask

  task automatic test_flush_wait();
    fetch_req = 1'b1; fetch_pc = 64'h2000;
    cyc();
    fetch_req = 1'b0; bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0; fetch_flush = 1'b1;
    cyc();
    fetch_flush = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'h22222222_11111111;
    #1;
    n_checks++; if (bus_respack !== 1'b1) begin n_fail++; $display("FAIL flush_respack got=%0b want=1", bus_respack); end
    cyc();
    bus_respcyc = 1'b0;
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL flush_recvd got=%0b want=0", sig_recvd); end
    cyc();
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL flush_recvd2 got=%0b want=0", sig_recvd); end
    fetch_req = 1'b1; fetch_pc = 64'h2004;
    cyc();
    n_checks++; if (sig_recvd !== 1'b1) begin n_fail++; $display("FAIL flush_hit_recvd got=%0b want=1", sig_recvd); end
    n_checks++; if (instr_out !== 32'h22222222) begin n_fail++; $display("FAIL flush_hit_instr got=%h want=22222222", instr_out); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_hit_bus_req got=%0b want=0", bus_req); end
    fetch_req = 1'b0;
    cyc();
  endtask

  task automatic test_flush_idle_resp();
    fetch_req = 1'b1; fetch_pc = 64'h2000; fetch_flush = 1'b1;
    cyc();
    n_checks++; if (sig_recvd !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%0b/%0b want=0/0", sig_recvd, bus_req); end
    fetch_flush = 1'b0;
    cyc();
    // Hit accepted at this edge; flush during the delivery cycle hides it.
    fetch_flush = 1'b1;
    #1;
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL flush_resp got=%0b want=0", sig_recvd); end
    fetch_flush = 1'b0;
    #1;
    n_checks++; if (sig_recvd !== 1'b1) begin n_fail++; $display("FAIL flush_resp_raw got=%0b want=1", sig_recvd); end
    fetch_req = 1'b0;
    cyc();
  endtask

  task automatic test_inval();
    fill(64'h3000, 64'h33333333_30303030);
    buf_inval = 1'b1;
    cyc();
    buf_inval = 1'b0;
    fetch_req = 1'b1; fetch_pc = 64'h3004;
    cyc();
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL inval_bus_req got=%0b want=1", bus_req); end
    n_checks++; if (bus_addr !== 64'h3000) begin n_fail++; $display("FAIL inval_bus_addr got=%h want=3000", bus_addr); end
    n_checks++; if (sig_recvd !== 1'b0) begin n_fail++; $display("FAIL inval_recvd got=%0b want=0", sig_recvd); end
    bus_ack = 1'b1;
    cyc();
    // Fill and invalidate together: delivered, but buffer stays invalid.
    bus_ack = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'h44444444_40404040; buf_inval = 1'b1;
    cyc();
    bus_respcyc = 1'b0; buf_inval = 1'b0; fetch_req = 1'b0;
    n_checks++; if (sig_recvd !== 1'b1) begin n_fail++; $display("FAIL inval_fill_recvd got=%0b want=1", sig_recvd); end
    n_checks++; if (instr_out !== 32'h44444444) begin n_fail++; $display("FAIL inval_fill_instr got=%h want=44444444", instr_out); end
    cyc();
    fetch_req = 1'b1; fetch_pc = 64'h3000;
    cyc();
    n_checks++; if (bus_req !== 1'b1 || sig_recvd !== 1'b0) begin n_fail++; $display("FAIL inval_win got=%0b/%0b want=1/0", bus_req, sig_recvd); end
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0; bus_respcyc = 1'b1;
    cyc();
    bus_respcyc = 1'b0; fetch_req = 1'b0;
    n_checks++; if (instr_out !== 32'h40404040) begin n_fail++; $display("FAIL inval_refetch got=%h want=40404040", instr_out); end
    cyc();
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    fetch_req = 1'b1; fetch_pc = 64'h4000;
    cyc();
    for (int i = 0; i < 10; i++) begin
      fetch_pc = 64'h5000 + 64'(i * 8);
      cyc();
      if (bus_req !== 1'b1 || bus_addr !== 64'h4000) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold bad_cycles=%0d want=0 (last req=%0b addr=%h)", bad, bus_req, bus_addr); end
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'h55555555_45454545;
    cyc();
    bus_respcyc = 1'b0; fetch_req = 1'b0;
    n_checks++; if (sig_recvd !== 1'b1 || instr_pc !== 64'h4000) begin n_fail++; $display("FAIL stall_resp got=%0b/%h want=1/4000", sig_recvd, instr_pc); end
    n_checks++; if (instr_out !== 32'h45454545) begin n_fail++; $display("FAIL stall_instr got=%h want=45454545", instr_out); end
    cyc();
  endtask

  task automatic test_reset_mid();
    fill(64'h1000, 64'hBBBBBBBB_AAAAAAAA);
    fetch_req = 1'b1; fetch_pc = 64'h6000;
    cyc();
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'h66666666_60606060;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus_respack !== 1'b0 || bus_req !== 1'b0 || sig_recvd !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl got=%0b/%0b/%0b want=0/0/0", bus_respack, bus_req, sig_recvd); end
    n_checks++; if (instr_out !== 32'h0 || instr_pc !== 64'h0 || bus_addr !== 64'h0) begin n_fail++; $display("FAIL rst_data got=%h/%h/%h want=0", instr_out, instr_pc, bus_addr); end
    bus_respcyc = 1'b0; fetch_req = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    fetch_req = 1'b1; fetch_pc = 64'h1004;
    cyc();
    n_checks++; if (bus_req !== 1'b1 || sig_recvd !== 1'b0) begin n_fail++; $display("FAIL rst_miss got=%0b/%0b want=1/0", bus_req, sig_recvd); end
    n_checks++; if (bus_addr !== 64'h1000) begin n_fail++; $display("FAIL rst_bus_addr got=%h want=1000", bus_addr); end
    fetch_req = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; fetch_req = 1'b0; fetch_pc = '0; fetch_flush = 1'b0;
    buf_inval = 1'b0; bus_ack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    test_reset_init();
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    test_miss();
    test_hit();
    test_flush_wait();
    test_flush_idle_resp();
    test_inval();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end

endmodule
